branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch prediction unit for the fetch stage: a direct-mapped branch target buffer (BTB) plus a pattern history table (PHT) of 2-bit saturating counters, selectable between bimodal and gshare indexing. Fetch queries it combinationally every cycle. Execute returns resolved outcomes, which train the tables. The block raises a registered mispredict/redirect pulse that the pipeline uses as its flush source, replacing the single-entry hazard logic.

## Interface
Parameters:
- PC_W, 8, program counter width; PC is word-addressed, fall-through = PC+1 mod 2^PC_W
- INDEX_W, 4, log2 of BTB/PHT entries (2^INDEX_W each); INDEX_W < PC_W
- GHR_W, 4, global history register width, 1..INDEX_W
- MODE, 0, 0 = bimodal index, 1 = gshare index
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  fetch lookup request this cycle
- pred_pc  in  PC_W  PC being fetched
- pred_taken  out  1  predicted taken
- pred_target  out  PC_W  predicted next PC
- pred_idx  out  INDEX_W  PHT index used; carried down the pipe to res_idx
- pred_ghr  out  GHR_W  GHR snapshot used; carried down the pipe to res_ghr
- res_valid  in  1  a branch resolved in execute this cycle
- res_pc  in  PC_W  PC of the resolved branch
- res_idx  in  INDEX_W  pred_idx captured at prediction
- res_ghr  in  GHR_W  pred_ghr captured at prediction
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- res_pred_taken  in  1  pred_taken captured at prediction
- res_pred_target  in  PC_W  pred_target captured at prediction
- mispredict  out  1  registered one-cycle flush pulse
- redirect_pc  out  PC_W  correct next PC, valid while mispredict=1
- branch_count  out  CNT_W  resolved branches, saturating
- mispredict_count  out  CNT_W  mispredictions, saturating

## Operation
- Storage:
  - BTB entry = {valid, tag = pc[PC_W-1:INDEX_W], target}.
  - PHT entry = 2-bit counter.
  - GHR is a GHR_W-bit shift register; the newest outcome is in bit 0.
- Reset values:
  - BTB valid = 0; PHT = 2'b01 (weakly not-taken); GHR = 0; counters = 0.
  - mispredict = 0; redirect_pc = 0.
- Lookup (combinational):
  - BTB index = pred_pc[INDEX_W-1:0].
  - PHT index = MODE 0: pred_pc[INDEX_W-1:0]; MODE 1: pred_pc[INDEX_W-1:0] XOR zero-extended GHR.
  - hit = BTB valid && tag match.
  - pred_taken = pred_valid && hit && PHT[idx][1].
  - pred_target = pred_taken ? BTB target : pred_pc+1.
  - pred_idx and pred_ghr are driven regardless of pred_valid.
- Speculative history:
  - On pred_valid && hit: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  - Lookups that miss the BTB leave GHR unchanged.
- Resolve (res_valid):
  - PHT[res_idx] increments toward 3 if res_taken, otherwise decrements toward 0. It saturates at 3 and 0.
  - If res_taken: BTB[res_pc[INDEX_W-1:0]] <= {1, res_pc tag, res_target}. This overwrites any alias.
  - Not-taken branches never allocate a BTB entry and never invalidate one.
  - branch_count increments, saturating at all-ones.
- Mispredict condition:
  - mis = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)).
  - On mis: mispredict <= 1; redirect_pc <= res_taken ? res_target : res_pc+1; mispredict_count increments, saturating.
  - The GHR is repaired: GHR <= {res_ghr[GHR_W-2:0], res_taken}.
- Simultaneous events:
  - GHR repair on mis has priority over a same-cycle speculative shift. The shift is dropped.
  - A same-cycle lookup and update of the same entry: the lookup returns the old contents (read-before-write).
- Reset mid-operation:
  - All state returns to reset values on that edge.
  - A res_valid in the reset cycle is ignored.

## Timing
- Lookup latency: 0 cycles (combinational from pred_pc and registered tables).
- Table, GHR and counter updates are visible from the cycle after the res_valid edge.
- mispredict is asserted for exactly 1 cycle, in the cycle after res_valid.
- Back-to-back mispredicting resolves produce back-to-back pulses, each carrying its own redirect_pc.
- No backpressure: one lookup and one resolve are accepted every cycle.
- With GHR_W = 1 the shift degenerates to GHR <= new bit.

## Test plan
- Reset, then pred_valid with pred_pc=0x10 → pred_taken=0, pred_target=0x11.
  - Then resolve 0x10 taken with target 0x40 and res_pred_taken=0 → next cycle mispredict=1, redirect_pc=0x40, mispredict_count=1.
- Saturation (MODE 0): after the above, a second taken resolve of 0x10 → lookup of 0x10 returns pred_taken=1, pred_target=0x40.
  - Two further taken resolves keep the counter at 3.
  - A single not-taken resolve leaves pred_taken=1 (counter 2).
- Alias: PC 0x10 and 0x20 share index 0 (INDEX_W=4). Resolve 0x20 taken with target 0x55 → lookup of 0x10 misses: pred_taken=0, target 0x11.
- Wrong target only: resolve with res_taken=1, res_pred_taken=1, res_target=0x30, res_pred_target=0x31 → mispredict=1, redirect_pc=0x30.
- Gshare (MODE 1): resolve a mispredict with res_ghr=4'b0101 and res_taken=1 while a BTB-hit lookup happens in the same cycle → GHR=4'b1011 next cycle, and the speculative shift is dropped.
- Resolve pc=0xFF not-taken with res_pred_taken=1 → redirect_pc=0x00 (wrap).
  - Assert reset while that mispredict pulse is pending → mispredict=0, all counters 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch-stage branch predictor.
//   A direct-mapped BTB and a table of 2-bit saturating counters (PHT) with
//   bimodal (MODE=0) or gshare (MODE=1) indexing. Fetch looks up
//   combinationally. Execute trains the tables and raises a registered flush
//   pulse when the prediction it carried down the pipe was wrong.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pred_*              fetch lookup: valid/pc in; taken/target/idx/ghr out
//   res_*               execute resolve: outcome plus the prediction it used
//   mispredict          one-cycle registered flush pulse
//   redirect_pc         correct next PC while mispredict=1
//   branch_count        saturating count of resolved branches
//   mispredict_count    saturating count of mispredictions
module branch_predict_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned GHR_W   = 4,
  parameter int unsigned MODE    = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pred_valid,
  input  logic [PC_W-1:0]    pred_pc,
  output logic               pred_taken,
  output logic [PC_W-1:0]    pred_target,
  output logic [INDEX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]   pred_ghr,
  input  logic               res_valid,
  input  logic [PC_W-1:0]    res_pc,
  input  logic [INDEX_W-1:0] res_idx,
  input  logic [GHR_W-1:0]   res_ghr,
  input  logic               res_taken,
  input  logic [PC_W-1:0]    res_target,
  input  logic               res_pred_taken,
  input  logic [PC_W-1:0]    res_pred_target,
  output logic               mispredict,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned TAG_W   = PC_W - INDEX_W;

  // Table storage
  logic                  btb_valid_q [ENTRIES];
  logic [TAG_W-1:0]      btb_tag_q   [ENTRIES];
  logic [PC_W-1:0]       btb_tgt_q   [ENTRIES];
  logic [1:0]            pht_q       [ENTRIES];

  logic [GHR_W-1:0]      ghr_q, ghr_d;
  logic                  mispredict_q, mispredict_d;
  logic [PC_W-1:0]       redirect_q, redirect_d;
  logic [CNT_W-1:0]      bcnt_q, bcnt_d;
  logic [CNT_W-1:0]      mcnt_q, mcnt_d;

  logic [INDEX_W-1:0]    lk_btb_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic                  mis_c;
  logic [1:0]            pht_cur;
  logic [1:0]            pht_nxt;

  // Lookup: reads registered tables only, so a same-cycle update is not seen
  always_comb begin
    lk_btb_idx  = pred_pc[INDEX_W-1:0];
    lk_tag      = pred_pc[PC_W-1:INDEX_W];
    pred_idx    = lk_btb_idx;
    if (MODE == 1) begin
      pred_idx = lk_btb_idx ^ INDEX_W'(ghr_q);
    end
    lk_hit      = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    pred_taken  = pred_valid && lk_hit && pht_q[pred_idx][1];
    pred_target = pred_taken ? btb_tgt_q[lk_btb_idx] : (pred_pc + PC_W'(1));
    pred_ghr    = ghr_q;
  end

  // Next-state: history, flush pulse, statistics, PHT counter step
  always_comb begin
    ghr_d        = ghr_q;
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    bcnt_d       = bcnt_q;
    mcnt_d       = mcnt_q;

    mis_c = res_valid &&
            ((res_taken != res_pred_taken) ||
             (res_taken && (res_target != res_pred_target)));

    // Truncating the concatenation keeps the newest GHR_W bits (also GHR_W=1)
    if (pred_valid && lk_hit) begin
      ghr_d = GHR_W'({ghr_q, pred_taken});
    end

    // Repair overrides any same-cycle speculative shift
    if (mis_c) begin
      ghr_d        = GHR_W'({res_ghr, res_taken});
      mispredict_d = 1'b1;
      redirect_d   = res_taken ? res_target : (res_pc + PC_W'(1));
      if (mcnt_q != '1) begin
        mcnt_d = mcnt_q + CNT_W'(1);
      end
    end

    if (res_valid && (bcnt_q != '1)) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end

    pht_cur = pht_q[res_idx];
    pht_nxt = pht_cur;
    if (res_taken) begin
      if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
    end
  end

  // State registers and table writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        pht_q[i]       <= 2'b01;
      end
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
    end else begin
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
      if (res_valid) begin
        pht_q[res_idx] <= pht_nxt;
        // Only taken branches allocate; an alias at the same index is evicted
        if (res_taken) begin
          btb_valid_q[res_pc[INDEX_W-1:0]] <= 1'b1;
          btb_tag_q[res_pc[INDEX_W-1:0]]   <= res_pc[PC_W-1:INDEX_W];
          btb_tgt_q[res_pc[INDEX_W-1:0]]   <= res_target;
        end
      end
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: a bimodal instance driven from a vector table, plus a
// gshare instance exercised by a short hand-written history sequence.
module tb_branch_predict_unit;

  logic       clk = 1'b0;
  logic       reset;

  // Bimodal instance signals
  logic       pv, rv, rt, rpt;
  logic [7:0] ppc, rpc, rtgt, rptgt;
  logic [3:0] ridx, rghr;
  logic       o_pt, o_mis;
  logic [7:0] o_ptgt, o_redir;
  logic [3:0] o_pidx, o_pghr;
  logic [15:0] o_bc, o_mc;

  // Gshare instance signals
  logic       g_pv, g_rv, g_rt, g_rpt;
  logic [7:0] g_ppc, g_rpc, g_rtgt, g_rptgt;
  logic [3:0] g_ridx, g_rghr;
  logic       g_pt, g_mis;
  logic [7:0] g_ptgt, g_redir;
  logic [3:0] g_pidx, g_pghr;
  logic [15:0] g_bc, g_mc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(8), .INDEX_W(4), .GHR_W(4), .MODE(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pv), .pred_pc(ppc), .pred_taken(o_pt), .pred_target(o_ptgt),
    .pred_idx(o_pidx), .pred_ghr(o_pghr),
    .res_valid(rv), .res_pc(rpc), .res_idx(ridx), .res_ghr(rghr),
    .res_taken(rt), .res_target(rtgt), .res_pred_taken(rpt),
    .res_pred_target(rptgt),
    .mispredict(o_mis), .redirect_pc(o_redir),
    .branch_count(o_bc), .mispredict_count(o_mc)
  );

  branch_predict_unit #(.PC_W(8), .INDEX_W(4), .GHR_W(4), .MODE(1), .CNT_W(16)) dut_g (
    .clk(clk), .reset(reset),
    .pred_valid(g_pv), .pred_pc(g_ppc), .pred_taken(g_pt), .pred_target(g_ptgt),
    .pred_idx(g_pidx), .pred_ghr(g_pghr),
    .res_valid(g_rv), .res_pc(g_rpc), .res_idx(g_ridx), .res_ghr(g_rghr),
    .res_taken(g_rt), .res_target(g_rtgt), .res_pred_taken(g_rpt),
    .res_pred_target(g_rptgt),
    .mispredict(g_mis), .redirect_pc(g_redir),
    .branch_count(g_bc), .mispredict_count(g_mc)
  );

  typedef struct {
    logic       pv;
    logic [7:0] ppc;
    logic       rv;
    logic [7:0] rpc;
    logic [3:0] ridx;
    logic       rt;
    logic [7:0] rtgt;
    logic       rpt;
    logic [7:0] rptgt;
    logic       e_pt;
    logic [7:0] e_ptgt;
    logic       e_mis;
    logic [7:0] e_redir;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic a_pv, input logic [7:0] a_ppc,
    input logic a_rv, input logic [7:0] a_rpc, input logic [3:0] a_ridx,
    input logic a_rt, input logic [7:0] a_rtgt,
    input logic a_rpt, input logic [7:0] a_rptgt,
    input logic a_ept, input logic [7:0] a_eptgt,
    input logic a_emis, input logic [7:0] a_eredir,
    input logic [15:0] a_ebc, input logic [15:0] a_emc);
    vec_t v;
    v.pv = a_pv; v.ppc = a_ppc; v.rv = a_rv; v.rpc = a_rpc; v.ridx = a_ridx;
    v.rt = a_rt; v.rtgt = a_rtgt; v.rpt = a_rpt; v.rptgt = a_rptgt;
    v.e_pt = a_ept; v.e_ptgt = a_eptgt; v.e_mis = a_emis; v.e_redir = a_eredir;
    v.e_bc = a_ebc; v.e_mc = a_emc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_main();
    pv = 1'b0; ppc = 8'h00; rv = 1'b0; rpc = 8'h00; ridx = 4'h0; rghr = 4'h0;
    rt = 1'b0; rtgt = 8'h00; rpt = 1'b0; rptgt = 8'h00;
  endtask

  task automatic idle_g();
    g_pv = 1'b0; g_ppc = 8'h00; g_rv = 1'b0; g_rpc = 8'h00; g_ridx = 4'h0;
    g_rghr = 4'h0; g_rt = 1'b0; g_rtgt = 8'h00; g_rpt = 1'b0; g_rptgt = 8'h00;
  endtask

  initial begin
    // pv ppc  rv rpc ridx rt rtgt rpt rptgt | pt ptgt mis redir bc mc
    vecs[0]  = mk(1'b1, 8'h10, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00,
                  1'b0, 8'h11, 1'b0, 8'h00, 16'd0, 16'd0);
    vecs[1]  = mk(1'b0, 8'h10, 1'b1, 8'h10, 4'h0, 1'b1, 8'h40, 1'b0, 8'h11,
                  1'b0, 8'h11, 1'b1, 8'h40, 16'd1, 16'd1);
    vecs[2]  = mk(1'b1, 8'h10, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00,
                  1'b1, 8'h40, 1'b0, 8'h00, 16'd1, 16'd1);
    vecs[3]  = mk(1'b1, 8'h10, 1'b1, 8'h10, 4'h0, 1'b1, 8'h40, 1'b1, 8'h40,
                  1'b1, 8'h40, 1'b0, 8'h00, 16'd2, 16'd1);
    vecs[4]  = mk(1'b1, 8'h10, 1'b1, 8'h10, 4'h0, 1'b1, 8'h40, 1'b1, 8'h40,
                  1'b1, 8'h40, 1'b0, 8'h00, 16'd3, 16'd1);
    vecs[5]  = mk(1'b1, 8'h10, 1'b1, 8'h10, 4'h0, 1'b1, 8'h40, 1'b1, 8'h40,
                  1'b1, 8'h40, 1'b0, 8'h00, 16'd4, 16'd1);
    vecs[6]  = mk(1'b1, 8'h10, 1'b1, 8'h10, 4'h0, 1'b0, 8'h00, 1'b1, 8'h40,
                  1'b1, 8'h40, 1'b1, 8'h11, 16'd5, 16'd2);
    vecs[7]  = mk(1'b1, 8'h10, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00,
                  1'b1, 8'h40, 1'b0, 8'h00, 16'd5, 16'd2);
    // alias 0x20 evicts 0x10; lookup in the same cycle still sees old entry
    vecs[8]  = mk(1'b1, 8'h10, 1'b1, 8'h20, 4'h0, 1'b1, 8'h55, 1'b0, 8'h21,
                  1'b1, 8'h40, 1'b1, 8'h55, 16'd6, 16'd3);
    // wrong target only, back-to-back with the previous pulse
    vecs[9]  = mk(1'b1, 8'h10, 1'b1, 8'h33, 4'h3, 1'b1, 8'h30, 1'b1, 8'h31,
                  1'b0, 8'h11, 1'b1, 8'h30, 16'd7, 16'd4);
    // hit without pred_valid must not predict taken
    vecs[10] = mk(1'b0, 8'h20, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00,
                  1'b0, 8'h21, 1'b0, 8'h00, 16'd7, 16'd4);
    // not-taken at 0xFF wraps the redirect to 0x00
    vecs[11] = mk(1'b1, 8'h20, 1'b1, 8'hFF, 4'hF, 1'b0, 8'h00, 1'b1, 8'h00,
                  1'b1, 8'h55, 1'b1, 8'h00, 16'd8, 16'd5);

    idle_main();
    idle_g();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mis",   32'(o_mis), 32'(1'b0));
    chk("reset_redir", 32'(o_redir), 32'(8'h00));
    chk("reset_bc",    32'(o_bc), 32'(16'd0));
    chk("reset_mc",    32'(o_mc), 32'(16'd0));
    chk("reset_ghr",   32'(g_pghr), 32'(4'h0));

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      pv = vecs[i].pv; ppc = vecs[i].ppc; rv = vecs[i].rv; rpc = vecs[i].rpc;
      ridx = vecs[i].ridx; rt = vecs[i].rt; rtgt = vecs[i].rtgt;
      rpt = vecs[i].rpt; rptgt = vecs[i].rptgt; rghr = 4'h0;
      #1;
      chk($sformatf("v%0d_pred_taken", i),  32'(o_pt), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d_pred_target", i), 32'(o_ptgt), 32'(vecs[i].e_ptgt));
      chk($sformatf("v%0d_pred_idx", i),    32'(o_pidx), 32'(vecs[i].ppc[3:0]));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mispredict", i), 32'(o_mis), 32'(vecs[i].e_mis));
      if (vecs[i].e_mis)
        chk($sformatf("v%0d_redirect", i), 32'(o_redir), 32'(vecs[i].e_redir));
      chk($sformatf("v%0d_branch_cnt", i), 32'(o_bc), 32'(vecs[i].e_bc));
      chk($sformatf("v%0d_mispr_cnt", i),  32'(o_mc), 32'(vecs[i].e_mc));
    end

    // Reset while the 0xFF pulse is showing; the resolve in the reset cycle is dropped
    @(negedge clk);
    reset = 1'b1;
    pv = 1'b0; rv = 1'b1; rpc = 8'h44; ridx = 4'h4; rt = 1'b1; rtgt = 8'h77;
    rpt = 1'b0; rptgt = 8'h45;
    @(posedge clk);
    #1;
    chk("rst_mid_mis",   32'(o_mis), 32'(1'b0));
    chk("rst_mid_redir", 32'(o_redir), 32'(8'h00));
    chk("rst_mid_bc",    32'(o_bc), 32'(16'd0));
    chk("rst_mid_mc",    32'(o_mc), 32'(16'd0));
    @(negedge clk);
    reset = 1'b0;
    idle_main();
    pv = 1'b1; ppc = 8'h44;
    #1;
    chk("rst_drop_taken",  32'(o_pt), 32'(1'b0));
    chk("rst_drop_target", 32'(o_ptgt), 32'(8'h45));
    ppc = 8'h20;
    #1;
    chk("rst_btb_clear", 32'(o_pt), 32'(1'b0));
    @(posedge clk);
    #1;
    chk("rst_post_mis", 32'(o_mis), 32'(1'b0));
    chk("rst_post_bc",  32'(o_bc), 32'(16'd0));

    // Gshare: allocate 0x10, GHR repaired to 0001
    @(negedge clk);
    idle_main();
    g_rv = 1'b1; g_rpc = 8'h10; g_ridx = 4'h0; g_rghr = 4'h0; g_rt = 1'b1;
    g_rtgt = 8'h40; g_rpt = 1'b0; g_rptgt = 8'h11;
    @(posedge clk);
    #1;
    chk("g_setup_mis", 32'(g_mis), 32'(1'b1));
    chk("g_setup_ghr", 32'(g_pghr), 32'(4'b0001));
    @(negedge clk);
    idle_g();
    g_pv = 1'b1; g_ppc = 8'h13;
    #1;
    chk("g_idx_xor", 32'(g_pidx), 32'(4'h2));
    // BTB hit lookup and mispredict repair in the same cycle
    g_ppc = 8'h10;
    g_rv = 1'b1; g_rpc = 8'h22; g_ridx = 4'h2; g_rghr = 4'b0101; g_rt = 1'b1;
    g_rtgt = 8'h66; g_rpt = 1'b0; g_rptgt = 8'h23;
    #1;
    chk("g_hit_taken", 32'(g_pt), 32'(1'b0));
    chk("g_hit_idx",   32'(g_pidx), 32'(4'h1));
    @(posedge clk);
    #1;
    chk("g_repair_ghr",   32'(g_pghr), 32'(4'b1011));
    chk("g_repair_mis",   32'(g_mis), 32'(1'b1));
    chk("g_repair_redir", 32'(g_redir), 32'(8'h66));
    @(negedge clk);
    idle_g();
    g_pv = 1'b1; g_ppc = 8'h10;
    #1;
    chk("g_idx_new_ghr", 32'(g_pidx), 32'(4'hB));
    @(posedge clk);
    #1;
    chk("g_spec_shift", 32'(g_pghr), 32'(4'b0110));
    chk("g_spec_mis",   32'(g_mis), 32'(1'b0));
    @(negedge clk);
    g_ppc = 8'h50;
    @(posedge clk);
    #1;
    chk("g_miss_hold", 32'(g_pghr), 32'(4'b0110));
    chk("g_bc",        32'(g_bc), 32'(16'd2));

    @(negedge clk);
    idle_g();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
